// File: rtl/perip_bus_arbiter.sv
// Two-master arbiter for the shared peripheral bus with bounded round-robin fairness.
// Grant and perip_* are same-cycle combinational; read data returns one cycle after grant; masters hold req until gnt.
module perip_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wen,
    input  logic [1:0]        m0_mask,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wen,
    input  logic [1:0]        m1_mask,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] perip_addr,
    output logic [DATA_W-1:0] perip_wdata,
    output logic              perip_wen,
    output logic [1:0]        perip_mask,
    input  logic [DATA_W-1:0] perip_rdata
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              wen;
        logic [1:0]        mask;
    } bus_req_t;

    logic             owner;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_pend;
    logic             rd_tag;

    logic     gnt0;
    logic     gnt1;
    logic     any_gnt;
    bus_req_t m0_bus;
    bus_req_t m1_bus;
    bus_req_t sel;

    assign m0_bus = '{addr: m0_addr, wdata: m0_wdata, wen: m0_wen, mask: m0_mask};
    assign m1_bus = '{addr: m1_addr, wdata: m1_wdata, wen: m1_wen, mask: m1_mask};

    // Under contention the owner keeps the bus until its burst allowance runs out.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case ({m1_req, m0_req})
                2'b01: gnt0 = 1'b1;
                2'b10: gnt1 = 1'b1;
                2'b11: begin
                    if (burst_cnt < CNT_W'(BURST_MAX)) begin
                        gnt1 = owner;
                        gnt0 = !owner;
                    end else begin
                        gnt1 = !owner;
                        gnt0 = owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign any_gnt = gnt0 | gnt1;

    always_comb begin
        sel = '0;
        if (gnt1)
            sel = m1_bus;
        else if (gnt0)
            sel = m0_bus;
    end

    assign m0_gnt      = gnt0;
    assign m1_gnt      = gnt1;
    assign perip_addr  = sel.addr;
    assign perip_wdata = sel.wdata;
    assign perip_wen   = sel.wen;
    assign perip_mask  = sel.mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= 1'b0;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_tag    <= 1'b0;
        end else begin
            // Idle cycles leave the fairness state untouched.
            if (any_gnt) begin
                if (gnt1 == owner) begin
                    if (burst_cnt != CNT_W'(BURST_MAX))
                        burst_cnt <= burst_cnt + CNT_W'(1);
                end else begin
                    owner     <= gnt1;
                    burst_cnt <= CNT_W'(1);
                end
            end
            rd_pend <= any_gnt && !sel.wen;
            if (any_gnt && !sel.wen)
                rd_tag <= gnt1;
        end
    end

    // Gating with rst drops a response that would land while reset is asserted.
    assign m0_rvalid = rd_pend && !rd_tag && !rst;
    assign m1_rvalid = rd_pend &&  rd_tag && !rst;
    assign m0_rdata  = m0_rvalid ? perip_rdata : '0;
    assign m1_rdata  = m1_rvalid ? perip_rdata : '0;

endmodule

// File: tb/tb_perip_bus_arbiter.sv
// Bench for perip_bus_arbiter: grant-history model checked every cycle plus directed literal checks.
module tb_perip_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_wen, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [1:0]    m0_mask;
    logic          m1_req, m1_wen, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [1:0]    m1_mask;
    logic [AW-1:0] perip_addr;
    logic [DW-1:0] perip_wdata, perip_rdata;
    logic          perip_wen;
    logic [1:0]    perip_mask;

    int errors = 0;
    int checks = 0;

    perip_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wen(m0_wen),
        .m0_mask(m0_mask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wen(m1_wen),
        .m1_mask(m1_mask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .perip_addr(perip_addr), .perip_wdata(perip_wdata), .perip_wen(perip_wen),
        .perip_mask(perip_mask), .perip_rdata(perip_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: fairness derived from the history of granted masters since reset.
    int hist[$];
    int pend_tag = -1;
    int exp_g    = -1;
    bit exp_rd   = 1'b0;
    int m_g, m_last, m_run;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_wen;
    logic [1:0]    e_mask;

    always @(negedge clk) begin
        m_g = -1;
        if (!rst) begin
            if (m0_req && m1_req) begin
                m_last = (hist.size() == 0) ? 0 : hist[hist.size()-1];
                m_run  = 0;
                for (int i = hist.size() - 1; i >= 0 && hist[i] == m_last && m_run < BM; i--)
                    m_run++;
                m_g = (m_run < BM) ? m_last : 1 - m_last;
            end else if (m0_req) begin
                m_g = 0;
            end else if (m1_req) begin
                m_g = 1;
            end
        end
        exp_g   = m_g;
        e_addr  = (m_g == 0) ? m0_addr  : (m_g == 1) ? m1_addr  : '0;
        e_wdata = (m_g == 0) ? m0_wdata : (m_g == 1) ? m1_wdata : '0;
        e_wen   = (m_g == 0) ? m0_wen   : (m_g == 1) ? m1_wen   : 1'b0;
        e_mask  = (m_g == 0) ? m0_mask  : (m_g == 1) ? m1_mask  : 2'b00;
        exp_rd  = (m_g >= 0) && !e_wen;
        chk("model_m0_gnt",      64'(m0_gnt),      64'(m_g == 0));
        chk("model_m1_gnt",      64'(m1_gnt),      64'(m_g == 1));
        chk("model_perip_addr",  64'(perip_addr),  64'(e_addr));
        chk("model_perip_wdata", 64'(perip_wdata), 64'(e_wdata));
        chk("model_perip_wen",   64'(perip_wen),   64'(e_wen));
        chk("model_perip_mask",  64'(perip_mask),  64'(e_mask));
        chk("model_m0_rvalid",   64'(m0_rvalid),   64'(pend_tag == 0 && !rst));
        chk("model_m1_rvalid",   64'(m1_rvalid),   64'(pend_tag == 1 && !rst));
        chk("model_m0_rdata",    64'(m0_rdata),    64'((pend_tag == 0 && !rst) ? perip_rdata : '0));
        chk("model_m1_rdata",    64'(m1_rdata),    64'((pend_tag == 1 && !rst) ? perip_rdata : '0));
    end

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            pend_tag = -1;
        end else begin
            if (exp_g >= 0) begin
                hist.push_back(exp_g);
                if (hist.size() > 8)
                    void'(hist.pop_front());
            end
            pend_tag = exp_rd ? exp_g : -1;
        end
    end

    // Starvation bound measured on the DUT's own grants.
    int w0 = 0;
    int w1 = 0;
    always @(negedge clk) begin
        if (rst) begin
            w0 = 0;
            w1 = 0;
        end else begin
            if (m0_gnt) begin
                chk("m0_wait_bound", 64'(w0 <= BM), 64'(1));
                w0 = 0;
            end else if (m0_req) w0++;
            else w0 = 0;
            if (m1_gnt) begin
                chk("m1_wait_bound", 64'(w1 <= BM), 64'(1));
                w1 = 0;
            end else if (m1_req) w1++;
            else w1 = 0;
        end
    end

    bit seq [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic g0s, g1s;

    initial begin
        rst = 1'b1;
        perip_rdata = '0;
        m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'h8000_0000; m0_wdata = 32'h1111; m0_mask = 2'b10;
        m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 32'h8000_0100; m1_wdata = 32'h2222; m1_mask = 2'b10;

        repeat (3) begin
            @(negedge clk);
            chk("rst_m0_gnt", 64'(m0_gnt), 64'(0));
            chk("rst_m1_gnt", 64'(m1_gnt), 64'(0));
            chk("rst_perip_wen", 64'(perip_wen), 64'(0));
            step();
        end
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("fair_m0_gnt", 64'(m0_gnt), 64'(!seq[i]));
            chk("fair_m1_gnt", 64'(m1_gnt), 64'(seq[i]));
            if (i == 0) chk("fair_first_wen", 64'(perip_wen), 64'(1));
            step();
        end

        m1_req = 1'b0;
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h8000_0010;
        perip_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("rd_m0_gnt", 64'(m0_gnt), 64'(1));
        chk("rd_perip_addr", 64'(perip_addr), 64'(32'h8000_0010));
        step();
        m0_req = 1'b0;
        perip_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_m0_rvalid", 64'(m0_rvalid), 64'(1));
        chk("rd_m0_rdata", 64'(m0_rdata), 64'(32'hDEAD_BEEF));
        chk("rd_m1_rvalid", 64'(m1_rvalid), 64'(0));
        chk("rd_m1_rdata", 64'(m1_rdata), 64'(0));
        step();
        perip_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("rd_no_dup", 64'(m0_rvalid), 64'(0));
        chk("idle_perip_addr", 64'(perip_addr), 64'(0));

        step();
        m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 32'h8000_0040;
        @(negedge clk);
        chk("rstrd_m1_gnt", 64'(m1_gnt), 64'(1));
        step();
        m1_req = 1'b0;
        rst = 1'b1;
        perip_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("rstrd_m1_rvalid_a", 64'(m1_rvalid), 64'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstrd_m1_rvalid_b", 64'(m1_rvalid), 64'(0));

        step();
        m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'h8010_0000; m0_wdata = 32'h1234; m0_mask = 2'b10;
        m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 32'h8000_0020; m1_mask = 2'b10;
        @(negedge clk);
        chk("mix_m0_gnt", 64'(m0_gnt), 64'(1));
        chk("mix_m1_gnt", 64'(m1_gnt), 64'(0));
        chk("mix_perip_wen", 64'(perip_wen), 64'(1));
        chk("mix_perip_addr", 64'(perip_addr), 64'(32'h8010_0000));
        chk("mix_perip_wdata", 64'(perip_wdata), 64'(32'h1234));
        chk("mix_perip_mask", 64'(perip_mask), 64'(2'b10));
        step();
        m0_req = 1'b0;
        @(negedge clk);
        chk("mix_m1_gnt2", 64'(m1_gnt), 64'(1));
        chk("mix_wr_no_rvalid", 64'(m0_rvalid), 64'(0));
        step();
        m1_req = 1'b0;
        perip_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("mix_m1_rvalid", 64'(m1_rvalid), 64'(1));
        chk("mix_m1_rdata", 64'(m1_rdata), 64'(32'hCAFE_0001));
        chk("mix_m0_rvalid", 64'(m0_rvalid), 64'(0));

        m0_wen = 1'b0;
        m1_wen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            m0_req = (k < 6) && (k % 2 == 0);
            m1_req = (k < 6) && (k % 2 == 1);
            m0_addr = 32'h0000_0100 + 32'(4 * k);
            m1_addr = 32'h0000_0200 + 32'(4 * k);
            perip_rdata = 32'h5000_0000 + 32'(k);
            @(negedge clk);
            if (k > 0) begin
                chk("b2b_m0_rvalid", 64'(m0_rvalid), 64'((k - 1) % 2 == 0));
                chk("b2b_m1_rvalid", 64'(m1_rvalid), 64'((k - 1) % 2 == 1));
                chk("b2b_rdata", 64'(((k - 1) % 2 == 0) ? m0_rdata : m1_rdata), 64'(32'h5000_0000 + 32'(k)));
            end
        end

        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            g0s = m0_gnt;
            g1s = m1_gnt;
            step();
            if (!m0_req || g0s) begin
                m0_req = ($urandom_range(0, 3) != 0);
                m0_addr = $urandom; m0_wdata = $urandom;
                m0_wen = 1'($urandom_range(0, 1)); m0_mask = 2'($urandom_range(0, 2));
            end
            if (!m1_req || g1s) begin
                m1_req = ($urandom_range(0, 3) != 0);
                m1_addr = $urandom; m1_wdata = $urandom;
                m1_wen = 1'($urandom_range(0, 1)); m1_mask = 2'($urandom_range(0, 2));
            end
            perip_rdata = $urandom;
        end

        @(negedge clk);
        step();
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) step();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
